ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits (legal 8..64).
REQ-002 SHALL have parameter TAG_W, default 6, width of the sideband tag carried with each op (e.g. {wb_en, rd[4:0]}).
REQ-003 SHALL have parameter MUL_EN, default 1, which enables the iterative multiplier when set to 1.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous kill of all held or in-flight work.
REQ-007 SHALL have port in_valid  input  1  an operation is presented.
REQ-008 SHALL have port in_ready  output  1  the stage accepts the operation this cycle.
REQ-009 SHALL have port in_op  input  4  operation code, as defined in REQ-015.
REQ-010 SHALL have ports in_a and in_b  input  XLEN  operands (rs1 and rs2 data).
REQ-011 SHALL have port in_tag  input  TAG_W  sideband carried unchanged to out_tag.
REQ-012 SHALL have port out_valid  output  1  a result is held.
REQ-013 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-014 SHALL have ports out_data (output, XLEN, the result) and out_tag (output, TAG_W, the tag of the result).

Function
REQ-015 SHALL decode in_op as follows:
- 0 NOP -> 0
- 1 ADD -> a+b
- 2 SUB -> a-b
- 3 PASS1 -> a
- 4 PASS2 -> b
- 5 AND, 6 OR, 7 XOR
- 8 SLT (signed) and 9 SLTU (unsigned) -> {0...,1} or 0
- 10 MUL -> low XLEN bits of unsigned a*b
- 11 MULHU -> high XLEN bits of unsigned a*b
- 12-15 -> 0, single-cycle
REQ-016 SHALL wrap ADD and SUB modulo 2^XLEN, with no carry or overflow output.
REQ-017 SHALL implement a 3-state FSM with states IDLE (nothing held), MUL (multiply iterating) and HOLD (out_valid=1).
REQ-018 SHALL drive in_ready = !flush && (IDLE || (HOLD && out_ready)), and in_ready SHALL be 0 in MUL.
REQ-019 SHALL treat an op as accepted only on a cycle where in_valid && in_ready.
REQ-020 SHALL, on accepting a single-cycle op (all ops except MUL/MULHU with MUL_EN=1), register the result and tag and enter HOLD, giving out_valid=1 on the next cycle (latency 1).
REQ-021 SHALL, on accepting MUL/MULHU with MUL_EN=1, latch the operands and tag, clear the 2*XLEN accumulator and enter MUL.
REQ-022 SHALL, in MUL, perform one shift-add step per cycle for exactly XLEN cycles, then enter HOLD with the selected half, so out_valid rises XLEN+1 cycles after acceptance.
REQ-023 SHALL, when MUL_EN=0, execute MUL/MULHU as single-cycle ops returning 0, and the multiplier logic SHALL be absent.
REQ-024 SHALL hold out_data and out_tag stable in HOLD while out_ready=0.
REQ-025 SHALL, in HOLD with out_ready=1 and no new acceptance, return to IDLE with out_valid=0 on the next cycle.
REQ-026 SHALL, in HOLD with out_ready=1 and a simultaneous acceptance, follow the new op with no bubble: single-cycle ops stay in HOLD with the new result, multiplies go to MUL.
REQ-027 SHALL give flush priority over every other event: state goes to IDLE, out_valid=0 next cycle, any in-flight multiply is discarded, and same-cycle in_valid is ignored.
REQ-028 SHALL keep the multiply iteration counter at ceil(log2(XLEN+1)) bits and never wrap it within one operation.

Reset
REQ-029 SHALL, while rst=0, immediately force state=IDLE, out_valid=0, out_data=0, out_tag=0, accumulator=0 and counter=0.
REQ-030 SHALL drive in_ready=0 while rst=0, and SHALL make in_ready reflect REQ-018 from the first clk edge after rst rises.
REQ-031 SHALL, when reset is asserted during MUL, abandon the multiply, and no result for it SHALL ever appear.

Verification
REQ-032 SHALL pass: ADD a=0xFFFFFFFF, b=1, tag=0x25, out_ready=1 -> next cycle out_valid=1, out_data=0, out_tag=0x25.
REQ-033 SHALL pass: SLT a=0x80000000, b=1 -> 1, and SLTU with the same operands -> 0, issued back-to-back with out_ready=1, producing one result per cycle with no bubble.
REQ-034 SHALL pass: MUL a=0x0001_0003, b=0x0002_0005 -> out_valid exactly 33 cycles after acceptance, out_data=0x000B_000F; MULHU with the same operands -> 0x0000_0002; in_ready=0 throughout MUL.
REQ-035 SHALL pass: SUB 5-7 with out_ready=0 for 4 cycles -> out_data=0xFFFFFFFE stable, in_ready=0, and exactly one transfer occurs when out_ready rises.
REQ-036 SHALL pass: flush on cycle 10 of a MUL together with in_valid=1 -> out_valid=0 next cycle, the new op is not accepted, and no multiply result ever appears.
REQ-037 SHALL pass: rst=0 asserted mid-MUL at an arbitrary phase -> all outputs 0 asynchronously; after release, ADD 2+3 -> out_data=5 with latency 1.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage with single-cycle ALU ops and an optional iterative
// shift-add multiplier, behind a one-entry valid/ready output register.
module ex_stage #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 6,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag
);
  localparam int CW = $clog2(XLEN + 1);
  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
  state_t state, nxt;
  logic alive, accept, is_mul, mul_done;
  logic [XLEN-1:0] alu, mul_res;
  assign is_mul    = (MUL_EN != 0) && (in_op == 4'd10 || in_op == 4'd11);
  // alive keeps in_ready low until the first clock edge after reset release
  assign in_ready  = alive && !flush && (state == IDLE || (state == HOLD && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = state == HOLD;
  always_comb begin
    alu = '0;
    case (in_op)
      4'd1:    alu = in_a + in_b;
      4'd2:    alu = in_a - in_b;
      4'd3:    alu = in_a;
      4'd4:    alu = in_b;
      4'd5:    alu = in_a & in_b;
      4'd6:    alu = in_a | in_b;
      4'd7:    alu = in_a ^ in_b;
      4'd8:    alu = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      4'd9:    alu = {{(XLEN-1){1'b0}}, in_a < in_b};
      default: alu = '0;
    endcase
  end
  always_comb
    nxt = flush                         ? IDLE :
          accept                        ? (is_mul ? MUL : HOLD) :
          (state == MUL && mul_done)    ? HOLD :
          (state == HOLD && out_ready)  ? IDLE : state;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      alive    <= 1'b0;
      out_data <= '0;
      out_tag  <= '0;
    end else begin
      state <= nxt;
      alive <= 1'b1;
      if (accept) out_tag <= in_tag;
      if (accept && !is_mul) out_data <= alu;
      else if (mul_done) out_data <= mul_res;
    end
  if (MUL_EN != 0) begin : g_mul
    logic [2*XLEN-1:0] acc, mcand, acc_next;
    logic [XLEN-1:0]   mplier;
    logic [CW-1:0]     cnt;
    logic              hi, busy;
    assign busy     = state == MUL;
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign mul_done = busy && cnt == CW'(XLEN - 1);
    assign mul_res  = hi ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        acc    <= '0;
        mcand  <= '0;
        mplier <= '0;
        cnt    <= '0;
        hi     <= 1'b0;
      end else if (accept && is_mul) begin
        acc    <= '0;
        mcand  <= {{XLEN{1'b0}}, in_a};
        mplier <= in_b;
        cnt    <= '0;
        hi     <= in_op[0];
      end else if (busy) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
  end else begin : g_nomul
    assign mul_done = 1'b0;
    assign mul_res  = '0;
  end
endmodule
